seg7_scan: RTL and testbench

SEG7_SCAN -- requirements
Module: seg7_scan

---
 rtl/seg7_scan.sv | 215 +++++++++++++++++++++
 tb/tb_seg7_scan.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan.sv
// seg7_scan: multiplexed seven-segment display driver.
// A prescaler paces a digit index across NUM_DIGITS digits. New display data
// is staged in a pending register and moved to the display register only at
// a frame boundary, so a frame never mixes old and new digits.
// Optional feature: define SEG7_LZB_EN to blank leading zero digits.
module seg7_scan #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] data,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic                    load_ack,
  output logic [7:0]              seg_out,
  output logic [NUM_DIGITS-1:0]   an_out
);

  // Index width is at least one bit so a single-digit build still elaborates.
  localparam int IDX_W     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  // Lookup tables are padded to a power of two so every index value is legal.
  localparam int NUM_SLOTS = 1 << IDX_W;
  localparam int PRE_W     = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);
  localparam logic [PRE_W-1:0] PRE_ONE  = PRE_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  // Scan state.
  logic [PRE_W-1:0]        r_presc;
  logic [IDX_W-1:0]        r_index;
  logic                    r_run;
  logic                    r_en_d;

  // Staged and live display contents.
  logic [4*NUM_DIGITS-1:0] r_pend_data;
  logic [NUM_DIGITS-1:0]   r_pend_dp;
  logic                    r_pend_flag;
  logic [4*NUM_DIGITS-1:0] r_disp_data;
  logic [NUM_DIGITS-1:0]   r_disp_dp;

  // Registered outputs.
  logic                    r_load_ack;
  logic [7:0]              r_seg;
  logic [NUM_DIGITS-1:0]   r_an;

  logic                    w_en_rise;
  logic                    w_term;
  logic                    w_wrap;
  logic                    w_xfer;
  logic [3:0]              w_nib     [NUM_SLOTS];
  logic                    w_dp_slot [NUM_SLOTS];
  logic [3:0]              w_cur_nib;
  logic                    w_cur_dp;
  logic [6:0]              w_dec;
  logic [6:0]              w_glyph;
  logic [NUM_DIGITS-1:0]   w_an_sel;

  // The first enabled cycle after a pause counts as prescaler value 0, so a
  // terminal count can never coincide with it.
  assign w_en_rise = en & ~r_en_d;
  assign w_term    = en & ~w_en_rise & (r_presc == PRE_LAST);
  assign w_wrap    = w_term & (r_index == IDX_LAST);
  assign w_xfer    = r_pend_flag & (w_wrap | w_en_rise);

  // Per-digit views of the display register, zero-padded beyond NUM_DIGITS.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
      if (gi < NUM_DIGITS) begin : g_real
        assign w_nib[gi]     = r_disp_data[4*gi +: 4];
        assign w_dp_slot[gi] = r_disp_dp[gi];
      end else begin : g_pad
        assign w_nib[gi]     = 4'h0;
        assign w_dp_slot[gi] = 1'b0;
      end
    end
  endgenerate

  // One-hot (active-high) digit select from the current index.
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_an
      assign w_an_sel[gi] = (r_index == IDX_W'(gi));
    end
  endgenerate

  assign w_cur_nib = w_nib[r_index];
  assign w_cur_dp  = w_dp_slot[r_index];

  // Hex nibble to active-low segment pattern g..a.
  always_comb begin
    w_dec = 7'h7F;
    case (w_cur_nib)
      4'h0: w_dec = 7'h40;
      4'h1: w_dec = 7'h79;
      4'h2: w_dec = 7'h24;
      4'h3: w_dec = 7'h30;
      4'h4: w_dec = 7'h19;
      4'h5: w_dec = 7'h12;
      4'h6: w_dec = 7'h02;
      4'h7: w_dec = 7'h78;
      4'h8: w_dec = 7'h00;
      4'h9: w_dec = 7'h10;
      4'hA: w_dec = 7'h08;
      4'hB: w_dec = 7'h03;
      4'hC: w_dec = 7'h46;
      4'hD: w_dec = 7'h21;
      4'hE: w_dec = 7'h06;
      4'hF: w_dec = 7'h0E;
      default: w_dec = 7'h7F;
    endcase
  end

`ifdef SEG7_LZB_EN
  // w_hi_zero[k] is set when digit k and every more significant digit are 0.
  logic w_hi_zero [NUM_SLOTS];
  logic w_blank;

  generate
    for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_lzb
      if (gi == NUM_SLOTS - 1) begin : g_top
        assign w_hi_zero[gi] = (w_nib[gi] == 4'h0);
      end else begin : g_chain
        assign w_hi_zero[gi] = (w_nib[gi] == 4'h0) & w_hi_zero[gi+1];
      end
    end
  endgenerate

  // Digit 0 always shows, so a value of zero still reads as "0".
  assign w_blank = (r_index != '0) & w_hi_zero[r_index];
  assign w_glyph = w_blank ? 7'h7F : w_dec;
`else
  assign w_glyph = w_dec;
`endif

  // Prescaler: counts while enabled, holds while disabled, restarts on re-enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= '0;
    end else if (en) begin
      if (w_en_rise) begin
        r_presc <= PRE_ONE;
      end else if (w_term) begin
        r_presc <= '0;
      end else begin
        r_presc <= r_presc + PRE_ONE;
      end
    end
  end

  // Digit index and start-up flag; the first terminal count after reset only
  // arms the display so that digit 0 gets a full first period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_index <= '0;
      r_run   <= 1'b0;
      r_en_d  <= 1'b0;
    end else begin
      r_en_d <= en;
      if (w_term) begin
        r_run <= 1'b1;
        if (r_run) begin
          r_index <= (r_index == IDX_LAST) ? '0 : r_index + IDX_ONE;
        end
      end
    end
  end

  // Pending/display registers; a load in a transfer cycle stays pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend_data <= '0;
      r_pend_dp   <= '0;
      r_pend_flag <= 1'b0;
      r_disp_data <= '0;
      r_disp_dp   <= '0;
      r_load_ack  <= 1'b0;
    end else begin
      r_load_ack <= w_xfer;
      if (w_xfer) begin
        r_disp_data <= r_pend_data;
        r_disp_dp   <= r_pend_dp;
      end
      if (load) begin
        r_pend_data <= data;
        r_pend_dp   <= dp_in;
        r_pend_flag <= 1'b1;
      end else if (w_xfer) begin
        r_pend_flag <= 1'b0;
      end
    end
  end

  // Registered segment and anode drive; dark while disabled or not yet armed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg <= 8'hFF;
      r_an  <= '1;
    end else if (en && r_run) begin
      r_seg <= {~w_cur_dp, w_glyph};
      r_an  <= ~w_an_sel;
    end else begin
      r_seg <= 8'hFF;
      r_an  <= '1;
    end
  end

  assign load_ack = r_load_ack;
  assign seg_out  = r_seg;
  assign an_out   = r_an;

endmodule

// File: tb/tb_seg7_scan.sv
// Self-checking bench for seg7_scan with NUM_DIGITS=4, REFRESH_DIV=4.
// Expected digit windows are queued when data is driven and compared as each
// new lit digit appears. Honours SEG7_LZB_EN if the build defines it.
`timescale 1ns/1ps
module tb_seg7_scan;

  localparam int ND  = 4;
  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        load = 1'b0;
  logic [15:0] data = 16'h0000;
  logic [3:0]  dp_in = 4'h0;
  logic        load_ack;
  logic [7:0]  seg_out;
  logic [3:0]  an_out;

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic [3:0] an;
    logic [7:0] seg;
  } exp_t;

  exp_t sb_q[$];

  logic [7:0] seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  seg7_scan #(.NUM_DIGITS(ND), .REFRESH_DIV(DIV)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .load     (load),
    .data     (data),
    .dp_in    (dp_in),
    .load_ack (load_ack),
    .seg_out  (seg_out),
    .an_out   (an_out)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // Reference segment pattern for digit k of a data word.
  function automatic logic [7:0] model_seg(input logic [15:0] d, input logic [3:0] dp, input int k);
    logic [7:0] s;
`ifdef SEG7_LZB_EN
    logic [15:0] hi;
    hi = d >> (4 * k);
`endif
    s = seg_tab[d[4*k +: 4]];
`ifdef SEG7_LZB_EN
    if (k != 0 && hi == 16'h0000) s = 8'hFF;
`endif
    if (dp[k]) s[7] = 1'b0;
    return s;
  endfunction

  function automatic logic [3:0] model_an(input int k);
    logic [3:0] one;
    one = 4'h1;
    return 4'hF ^ (one << k);
  endfunction

  task automatic push_digits(input logic [15:0] d, input logic [3:0] dp, input int from, input int upto);
    exp_t e;
    for (int k = from; k <= upto; k++) begin
      e.an  = model_an(k);
      e.seg = model_seg(d, dp, k);
      sb_q.push_back(e);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Drains n expected windows, comparing each newly lit digit; counts load_ack pulses seen.
  task automatic collect(input int n, input int budget, output int acks);
    logic [3:0] prev;
    int got;
    exp_t e;
    prev = an_out;
    got  = 0;
    acks = 0;
    for (int c = 0; c < budget && got < n; c++) begin
      cyc();
      if (load_ack === 1'b1) acks++;
      if (an_out !== 4'hF && an_out !== prev) begin
        n_vec++;
        if (sb_q.size() == 0) begin
          n_err++;
          $display("FAIL scan_unexpected: an_out=%b seg_out=%h, required no further digit", an_out, seg_out);
        end else begin
          e = sb_q.pop_front();
          if (an_out !== e.an || seg_out !== e.seg) begin
            n_err++;
            $display("FAIL scan_digit: an_out=%b seg_out=%h, required an_out=%b seg_out=%h",
                     an_out, seg_out, e.an, e.seg);
          end
        end
        got++;
      end
      prev = an_out;
    end
    if (got < n) begin
      n_vec++;
      n_err++;
      $display("FAIL scan_timeout: %0d digits seen, required %0d", got, n);
      sb_q.delete();
    end
  endtask

  // Waits for the first sample of a window in which digit 'want' is lit.
  task automatic wait_window(input logic [3:0] want);
    logic [3:0] prev;
    bit found;
    prev  = an_out;
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      cyc();
      if (an_out === want && prev !== want) found = 1'b1;
      prev = an_out;
    end
    if (!found) begin
      n_vec++;
      n_err++;
      $display("FAIL window_timeout: an_out=%b, required window %b", an_out, want);
    end
  endtask

  // Waits for load_ack and checks it lands on the frame wrap (digit 3 still lit).
  task automatic wait_ack(input int budget);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < budget && !seen; c++) begin
      cyc();
      if (load_ack === 1'b1) seen = 1'b1;
    end
    n_vec++;
    if (!seen) begin
      n_err++;
      $display("FAIL ack_timeout: load_ack=%b, required 1 within %0d cycles", load_ack, budget);
    end else if (an_out !== 4'h7) begin
      n_err++;
      $display("FAIL ack_at_wrap: an_out=%b at load_ack, required 0111", an_out);
    end
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] p);
    data  = d;
    dp_in = p;
    load  = 1'b1;
    cyc();
    load  = 1'b0;
  endtask

  task automatic test_reset();
    int acks;
    en    = 1'b1;
    rst_n = 1'b0;
    cyc();
    cyc();
    n_vec++;
    if (seg_out !== 8'hFF || an_out !== 4'hF || load_ack !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state: seg_out=%h an_out=%b load_ack=%b, required FF 1111 0", seg_out, an_out, load_ack);
    end
    rst_n = 1'b1;
    for (int k = 1; k <= DIV; k++) begin
      cyc();
      n_vec++;
      if (seg_out !== 8'hFF || an_out !== 4'hF) begin
        n_err++;
        $display("FAIL startup_dark cycle %0d: seg_out=%h an_out=%b, required FF 1111", k, seg_out, an_out);
      end
    end
    cyc();
    n_vec++;
    if (an_out !== 4'hE || seg_out !== model_seg(16'h0000, 4'h0, 0)) begin
      n_err++;
      $display("FAIL first_digit: an_out=%b seg_out=%h, required 1110 %h", an_out, seg_out, model_seg(16'h0000, 4'h0, 0));
    end
    push_digits(16'h0000, 4'h0, 1, 3);
    collect(3, 20, acks);
    n_vec++;
    if (acks != 0) begin
      n_err++;
      $display("FAIL reset_no_ack: %0d acks, required 0", acks);
    end
  endtask

  task automatic test_load();
    int acks;
    wait_window(4'hD);
    do_load(16'h12AF, 4'b0100);
    push_digits(16'h0000, 4'h0, 2, 3);
    collect(2, 20, acks);
    n_vec++;
    if (acks != 0) begin
      n_err++;
      $display("FAIL load_early_ack: %0d acks before wrap, required 0", acks);
    end
    wait_ack(10);
    push_digits(16'h12AF, 4'b0100, 0, 3);
    collect(4, 30, acks);
    n_vec++;
    if (acks != 0) begin
      n_err++;
      $display("FAIL ack_width: %0d extra acks, required 0", acks);
    end
  endtask

  task automatic test_last_write();
    int acks;
    wait_window(4'hD);
    do_load(16'h1111, 4'h0);
    do_load(16'h2222, 4'h0);
    push_digits(16'h12AF, 4'b0100, 2, 3);
    collect(2, 20, acks);
    n_vec++;
    if (acks != 0) begin
      n_err++;
      $display("FAIL lastwrite_early_ack: %0d acks, required 0", acks);
    end
    wait_ack(10);
    push_digits(16'h2222, 4'h0, 0, 3);
    push_digits(16'h2222, 4'h0, 0, 3);
    collect(8, 60, acks);
    n_vec++;
    if (acks != 0) begin
      n_err++;
      $display("FAIL lastwrite_single_ack: %0d extra acks, required 0", acks);
    end
  endtask

  task automatic test_enable();
    int lit;
    bit done;
    wait_window(4'hB);
    en = 1'b0;
    for (int k = 0; k < 10; k++) begin
      cyc();
      n_vec++;
      if (seg_out !== 8'hFF || an_out !== 4'hF) begin
        n_err++;
        $display("FAIL disabled_dark cycle %0d: seg_out=%h an_out=%b, required FF 1111", k, seg_out, an_out);
      end
    end
    en   = 1'b1;
    lit  = 0;
    done = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      cyc();
      if (an_out === 4'hB && seg_out === model_seg(16'h2222, 4'h0, 2)) lit++;
      else done = 1'b1;
    end
    n_vec++;
    if (lit != DIV) begin
      n_err++;
      $display("FAIL resume_period: digit 2 lit %0d cycles, required %0d", lit, DIV);
    end
    n_vec++;
    if (an_out !== 4'h7 || seg_out !== model_seg(16'h2222, 4'h0, 3)) begin
      n_err++;
      $display("FAIL resume_next: an_out=%b seg_out=%h, required 0111 %h", an_out, seg_out, model_seg(16'h2222, 4'h0, 3));
    end
  endtask

  task automatic test_back_to_back();
    int acks;
    wait_window(4'hD);
    do_load(16'h3456, 4'b0001);
    wait_window(4'h7);
    cyc();
    cyc();
    data  = 16'h789C;
    dp_in = 4'b1000;
    load  = 1'b1;
    cyc();
    load  = 1'b0;
    n_vec++;
    if (load_ack !== 1'b1 || an_out !== 4'h7) begin
      n_err++;
      $display("FAIL b2b_first_ack: load_ack=%b an_out=%b, required 1 0111", load_ack, an_out);
    end
    push_digits(16'h3456, 4'b0001, 0, 3);
    push_digits(16'h789C, 4'b1000, 0, 3);
    collect(8, 60, acks);
    n_vec++;
    if (acks != 1) begin
      n_err++;
      $display("FAIL b2b_second_ack: %0d acks, required 1", acks);
    end
  endtask

  task automatic test_patterns();
    logic [15:0] pat_d [4];
    logic [3:0]  pat_p [4];
    int acks;
    pat_d = '{16'h0005, 16'h0000, 16'hE0B0, 16'h0300};
    pat_p = '{4'b0000, 4'b0000, 4'b1010, 4'b0001};
    for (int i = 0; i < 4; i++) begin
      wait_window(4'hE);
      do_load(pat_d[i], pat_p[i]);
      wait_ack(20);
      push_digits(pat_d[i], pat_p[i], 0, 3);
      collect(4, 30, acks);
      n_vec++;
      if (acks != 0) begin
        n_err++;
        $display("FAIL pattern_%0d_ack: %0d extra acks, required 0", i, acks);
      end
    end
  endtask

  task automatic test_reset_pending();
    int acks;
    wait_window(4'hD);
    do_load(16'h5555, 4'b1111);
    cyc();
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (seg_out !== 8'hFF || an_out !== 4'hF || load_ack !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset: seg_out=%h an_out=%b load_ack=%b, required FF 1111 0", seg_out, an_out, load_ack);
    end
    cyc();
    cyc();
    rst_n = 1'b1;
    push_digits(16'h0000, 4'h0, 0, 3);
    push_digits(16'h0000, 4'h0, 0, 3);
    collect(8, 60, acks);
    n_vec++;
    if (acks != 0) begin
      n_err++;
      $display("FAIL reset_discard_ack: %0d acks, required 0", acks);
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_last_write();
    test_enable();
    test_back_to_back();
    test_patterns();
    test_reset_pending();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
